chan_mux_scan: RTL and testbench

Parametrised, registered N-channel, W-bit data multiplexer with a manual-select mode and an automatic scan mode. Scan mode steps through enabled channels at a programmable period, which makes the block suitable for display time-multiplexing. A per-channel enable mask forces masked channels to zero and skips them during scan. The block sits between the game datapath (several W-bit status/score words) and the display driver, and replaces the fixed 2:1 64-bit selector.

---
 rtl/chan_mux_scan_pkg.sv | 12 +
 rtl/chan_mux_scan_next_en_chan.sv | 43 ++++
 rtl/chan_mux_scan.sv | 90 +++++++++
 tb/tb_chan_mux_scan.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_mux_scan_pkg.sv
// chan_mux_scan shared definitions: mode encodings and default sizes.
// No ports; imported by chan_mux_scan and next_en_chan.
package chan_mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int DEF_W     = 64;
  localparam int DEF_SEL_W = 2;
  localparam int DEF_DIV_W = 16;

endpackage

// File: rtl/chan_mux_scan_next_en_chan.sv
// next_en_chan: next enabled channel after cur, wrapping, ending at cur.
// Ports: cur, en_mask in; nxt out (cur when nothing else is enabled).
module next_en_chan
  import chan_mux_scan_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [SEL_W-1:0]      cur,
  input  logic [2**SEL_W-1:0]   en_mask,
  output logic [SEL_W-1:0]      nxt
);

  localparam int N = 2**SEL_W;

  logic [N-1:0]     rot;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] off;
  logic             any;

  // rot[i] is the enable of channel cur+1+i, so the
  // lowest set bit of rot is the nearest enabled channel
  always_comb begin
    rot = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx    = cur + SEL_W'(i + 1);
      rot[i] = en_mask[idx];
    end
  end

  always_comb begin
    off = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = SEL_W'(i);
        any = 1'b1;
      end
    end
    nxt = any ? cur + off + SEL_W'(1) : cur;
  end

endmodule

// File: rtl/chan_mux_scan.sv
// chan_mux_scan: registered N-channel mux with manual select and timed scan.
// Ports: din/sel/mode/period/hold/en_mask in; o, ch, tick registered out.
module chan_mux_scan
  import chan_mux_scan_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int SEL_W = DEF_SEL_W,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [(2**SEL_W)*W-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic [DIV_W-1:0]        period,
  input  logic                    hold,
  input  logic [2**SEL_W-1:0]     en_mask,
  output logic [W-1:0]            o,
  output logic [SEL_W-1:0]        ch,
  output logic                    tick
);

  localparam int N = 2**SEL_W;

  logic [W-1:0]     chans [N];
  logic [SEL_W-1:0] cur;
  logic [SEL_W-1:0] cur_d;
  logic [SEL_W-1:0] nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] cnt_eff;
  logic             tick_d;
  logic             mode_q;
  logic             rise;

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign chans[k] = din[k*W +: W];
  end

  next_en_chan #(
    .SEL_W   (SEL_W)
  ) u_next (
    .cur     (cur),
    .en_mask (en_mask),
    .nxt     (nxt)
  );

  // a fresh scan always starts a full dwell
  assign rise    = (mode == MODE_SCAN) && (mode_q == MODE_MANUAL);
  assign cnt_eff = rise ? '0 : cnt;

  // manual beats hold, hold beats terminal count
  always_comb begin
    cur_d  = cur;
    cnt_d  = cnt;
    tick_d = 1'b0;
    if (mode == MODE_MANUAL) begin
      cur_d = sel;
      cnt_d = '0;
    end else if (hold) begin
      cur_d = cur;
      cnt_d = cnt;
    end else if (cnt_eff >= period) begin
      cur_d  = nxt;
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_eff + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= '0;
      cnt    <= '0;
      mode_q <= MODE_MANUAL;
      tick   <= 1'b0;
      ch     <= '0;
      o      <= '0;
    end else begin
      cur    <= cur_d;
      cnt    <= cnt_d;
      mode_q <= mode;
      tick   <= tick_d;
      ch     <= cur;
      o      <= en_mask[cur] ? chans[cur] : '0;
    end
  end

endmodule

// File: tb/tb_chan_mux_scan.sv
// tb_chan_mux_scan: vector table plus scoreboarded cycle model.
// Drives chan_mux_scan with W=64, N=4, DIV_W=16.
module tb_chan_mux_scan;

  logic          clk;
  logic          rst_n;
  logic [255:0]  din;
  logic [1:0]    sel;
  logic          mode;
  logic [15:0]   period;
  logic          hold;
  logic [3:0]    en_mask;
  logic [63:0]   o;
  logic [1:0]    ch;
  logic          tick;

  int vectors;
  int miscompares;

  typedef struct {
    logic [63:0] o;
    logic [1:0]  ch;
    logic        tick;
  } exp_t;

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  mask;
    logic [63:0] o;
    logic [1:0]  ch;
  } vec_t;

  exp_t sbq [$];
  vec_t tbl [6];

  logic [1:0]  m_cur;
  logic [15:0] m_cnt;

  chan_mux_scan dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .sel     (sel),
    .mode    (mode),
    .period  (period),
    .hold    (hold),
    .en_mask (en_mask),
    .o       (o),
    .ch      (ch),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] mnxt(input logic [1:0] c,
                                      input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] idx;
    r = c;
    for (int i = 3; i >= 1; i--) begin
      idx = c + 2'(i);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  function automatic logic [63:0] chdat(input logic [1:0] k);
    return 64'h1111_0000_0000_0000 | 64'(k);
  endfunction

  task automatic mreset();
    m_cur = '0;
    m_cnt = '0;
    sbq.delete();
  endtask

  // model one clock, push expectation, clock DUT, pop and compare
  task automatic cyc();
    exp_t e;
    exp_t g;
    e.o    = en_mask[m_cur] ? din[m_cur*64 +: 64] : 64'h0;
    e.ch   = m_cur;
    e.tick = 1'b0;
    if (!mode) begin
      m_cur = sel;
      m_cnt = '0;
    end else if (!hold) begin
      if (m_cnt >= period) begin
        m_cnt  = '0;
        m_cur  = mnxt(m_cur, en_mask);
        e.tick = 1'b1;
      end else begin
        m_cnt = m_cnt + 16'd1;
      end
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      g = sbq.pop_front();
      chk("sb_o", o, g.o);
      chk("sb_ch", 64'(ch), 64'(g.ch));
      chk("sb_tick", 64'(tick), 64'(g.tick));
    end
  endtask

  initial begin
    logic [1:0] pch;
    logic [1:0] fch;
    int n;
    vectors     = 0;
    miscompares = 0;
    tbl[0] = '{2'd2, 4'b1111, chdat(2'd2), 2'd2};
    tbl[1] = '{2'd2, 4'b1011, 64'h0,       2'd2};
    tbl[2] = '{2'd1, 4'b1111, chdat(2'd1), 2'd1};
    tbl[3] = '{2'd3, 4'b0111, 64'h0,       2'd3};
    tbl[4] = '{2'd0, 4'b1111, chdat(2'd0), 2'd0};
    tbl[5] = '{2'd3, 4'b1111, chdat(2'd3), 2'd3};

    for (int k = 0; k < 4; k++) din[k*64 +: 64] = chdat(2'(k));
    rst_n   = 1'b0;
    sel     = 2'd0;
    mode    = 1'b0;
    period  = 16'd0;
    hold    = 1'b0;
    en_mask = 4'b1111;
    mreset();

    // reset values with live data present
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o", o, 64'h0);
    chk("rst_ch", 64'(ch), 64'h0);
    chk("rst_tick", 64'(tick), 64'h0);
    rst_n = 1'b1;

    // manual select table
    for (int i = 0; i < 6; i++) begin
      sel     = tbl[i].sel;
      en_mask = tbl[i].mask;
      cyc();
      cyc();
      chk($sformatf("man%0d_o", i), o, tbl[i].o);
      chk($sformatf("man%0d_ch", i), 64'(ch), 64'(tbl[i].ch));
    end

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_o", o, 64'h0);
    chk("arst_ch", 64'(ch), 64'h0);
    chk("arst_tick", 64'(tick), 64'h0);
    mreset();

    // scan with dwell of 4 from release
    @(posedge clk);
    #1;
    mode    = 1'b1;
    period  = 16'd3;
    en_mask = 4'b1111;
    rst_n   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      chk($sformatf("dwell%0d_ch", i), 64'(ch), 64'(((i - 1) / 4) % 4));
      chk($sformatf("dwell%0d_tick", i), 64'(tick), 64'(i % 4 == 0));
    end

    // skip masked channels
    en_mask = 4'b1010;
    period  = 16'd0;
    pch     = ch;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("skip_tick", 64'(tick), 64'd1);
      if (i >= 2) begin
        chk("skip_ch_odd", 64'(ch == 2'd1 || ch == 2'd3), 64'd1);
        chk("skip_ch_alt", 64'(ch != pch), 64'd1);
      end
      pch = ch;
    end
    en_mask = 4'b0000;
    fch     = 2'd0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("zmask_o", o, 64'h0);
      chk("zmask_tick", 64'(tick), 64'd1);
      if (i == 2) fch = ch;
      if (i > 2) chk("zmask_ch", 64'(ch), 64'(fch));
    end

    // hold at cnt=5, then shrink period
    en_mask = 4'b1111;
    period  = 16'd10;
    n       = 0;
    while (m_cnt != 16'd5 && n < 40) begin
      cyc();
      n++;
    end
    chk("hold_align", 64'(m_cnt), 64'd5);
    hold = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("hold_tick", 64'(tick), 64'd0);
    end
    hold   = 1'b0;
    period = 16'd2;
    cyc();
    chk("shrink_tick", 64'(tick), 64'd1);

    // manual -> scan -> manual
    mode = 1'b0;
    sel  = 2'd3;
    cyc();
    cyc();
    mode   = 1'b1;
    period = 16'd1;
    cyc();
    chk("m2s_tick0", 64'(tick), 64'd0);
    cyc();
    chk("m2s_tick1", 64'(tick), 64'd1);
    cyc();
    chk("m2s_ch", 64'(ch), 64'd0);
    mode = 1'b0;
    sel  = 2'd1;
    cyc();
    cyc();
    chk("s2m_ch", 64'(ch), 64'd1);
    chk("s2m_o", o, chdat(2'd1));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
